// File: rtl/hold_meter_pkg.sv
// Shared definitions for the hold-rate meter: FSM encoding, the frequency unit
// width used by the hold generator, and a saturating increment helper.
package hold_meter_pkg;

  // Width of all frequency-unit quantities (0.1 MHz steps).
  localparam int FREQ_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] value);
    return (value == {FREQ_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/hold_meter_if.sv
// Control/status bundle of the hold meter: the monitored HOLD line and its
// configuration in one direction, the measurement results in the other.
interface hold_meter_if;
  import hold_meter_pkg::*;

  logic              enable;
  logic              hold;
  logic [FREQ_W-1:0] fref;
  logic [FREQ_W-1:0] freq_out;
  logic [FREQ_W-1:0] max_stall;
  logic              valid;
  logic              busy;
  logic              err;

  modport master (
    output enable, hold, fref,
    input  freq_out, max_stall, valid, busy, err
  );

  modport slave (
    input  enable, hold, fref,
    output freq_out, max_stall, valid, busy, err
  );

endinterface

// File: rtl/hold_meter_run_tracker.sv
// Tracks the current run of consecutive hold=0 samples and the longest run
// seen since the last clear. max_next already includes the sample presented
// this cycle so the owner can publish it on the window's last sample.
module hold_run_tracker
  import hold_meter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              sample,
  input  logic              hold,
  output logic [FREQ_W-1:0] max_next
);

  logic [FREQ_W-1:0] run_reg;
  logic [FREQ_W-1:0] max_reg;
  logic [FREQ_W-1:0] run_next;

  // Run length and running maximum including the current sample.
  always_comb begin
    run_next = hold ? '0 : sat_inc(run_reg);
    max_next = (run_next > max_reg) ? run_next : max_reg;
  end

  // Clear wins over sample so a window boundary starts from zero.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      run_reg <= '0;
      max_reg <= '0;
    end else if (sample) begin
      run_reg <= run_next;
      max_reg <= max_next;
    end
  end

endmodule

// File: rtl/hold_meter.sv
// Passive monitor of the CPU HOLD line. Counts running cycles over a window of
// fref * 2**AVG_LOG2 reference cycles and publishes the per-block average
// together with the longest stall run in that window.
module hold_meter
  import hold_meter_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  hold_meter_if.slave  bus
);

  localparam int ACC_W = FREQ_W + AVG_LOG2;
  localparam int BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'((2 ** AVG_LOG2) - 1);
  localparam logic [FREQ_W-1:0] FREF_MIN = FREQ_W'(2);

  state_t state_reg;
  state_t state_next;

  logic [FREQ_W-1:0] fref_q_reg;
  logic [FREQ_W-1:0] pos_reg;
  logic [BLK_W-1:0]  blk_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  acc_next;
  logic [FREQ_W-1:0] freq_reg;
  logic [FREQ_W-1:0] max_stall_reg;
  logic              valid_reg;
  logic              err_reg;
  logic [FREQ_W-1:0] max_next;

  logic fref_bad;
  logic pos_last;
  logic last_sample;
  logic latch_fref;
  logic clear_cnt;
  logic sample;
  logic publish;
  logic set_err;
  logic clr_err;

  // Window position decode and accumulator including the current sample.
  always_comb begin
    fref_bad    = (bus.fref < FREF_MIN);
    pos_last    = (pos_reg == fref_q_reg - 1'b1);
    last_sample = pos_last && (blk_reg == BLK_LAST);
    acc_next    = acc_reg + ACC_W'(bus.hold);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath control; dropping enable aborts from any state.
  always_comb begin
    state_next = state_reg;
    latch_fref = 1'b0;
    clear_cnt  = 1'b0;
    sample     = 1'b0;
    publish    = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    if (!bus.enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ARM;
        end
        ST_ARM: begin
          latch_fref = 1'b1;
          if (fref_bad) begin
            set_err    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            clr_err    = 1'b1;
            clear_cnt  = 1'b1;
            state_next = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          sample = 1'b1;
          if (last_sample) begin
            // Publish, re-latch fref and restart the next window with no gap.
            publish    = 1'b1;
            latch_fref = 1'b1;
            clear_cnt  = 1'b1;
            if (fref_bad) begin
              set_err    = 1'b1;
              state_next = ST_IDLE;
            end else begin
              clr_err = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Window counters, fref latch, error flag and published results.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fref_q_reg    <= '0;
      pos_reg       <= '0;
      blk_reg       <= '0;
      acc_reg       <= '0;
      freq_reg      <= '0;
      max_stall_reg <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg <= publish;
      if (latch_fref) begin
        fref_q_reg <= bus.fref;
      end
      if (set_err) begin
        err_reg <= 1'b1;
      end else if (clr_err) begin
        err_reg <= 1'b0;
      end
      if (publish) begin
        freq_reg      <= acc_next[ACC_W-1 -: FREQ_W];
        max_stall_reg <= max_next;
      end
      if (clear_cnt) begin
        pos_reg <= '0;
        blk_reg <= '0;
        acc_reg <= '0;
      end else if (sample) begin
        acc_reg <= acc_next;
        if (pos_last) begin
          pos_reg <= '0;
          blk_reg <= (blk_reg == BLK_LAST) ? '0 : blk_reg + 1'b1;
        end else begin
          pos_reg <= pos_reg + 1'b1;
        end
      end
    end
  end

  hold_run_tracker u_run_tracker (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear_cnt),
    .sample   (sample),
    .hold     (bus.hold),
    .max_next (max_next)
  );

  assign bus.freq_out  = freq_reg;
  assign bus.max_stall = max_stall_reg;
  assign bus.valid     = valid_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_hold_meter.sv
// Self-checking bench for hold_meter: directed sequence with patterned and
// random HOLD streams, expected results computed from the sampled stream.
module tb_hold_meter;
  import hold_meter_pkg::*;

  localparam int AVG_LOG2 = 2;
  localparam int NBLK     = 1 << AVG_LOG2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  hold_meter_if bus ();

  hold_meter #(.AVG_LOG2(AVG_LOG2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int tests     = 0;
  int fails     = 0;
  int last_freq = 0;
  int last_max  = 0;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic hold_gen(input int mode, input int i, input int p);
    case (mode)
      0:       return (i % (2 * p)) < p;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return $urandom_range(0, 99) < p;
    endcase
  endfunction

  // Enable from idle: one cycle to see enable, one ARM cycle.
  task automatic start(input string tag, input int fr);
    bus.enable = 1'b1;
    bus.fref   = 8'(fr);
    tick();
    check(tag, "busy_arm", 32'(bus.busy), 1);
    tick();
    check(tag, "err_arm", 32'(bus.err), (fr < 2) ? 1 : 0);
  endtask

  // One full window of fr*NBLK samples; the result must appear right after
  // the last sample and nowhere before it.
  task automatic run_window(input string tag, input int fr, input int mode,
                            input int p, input int chg_at, input int chg_fref);
    int   n     = fr * NBLK;
    int   ones  = 0;
    int   run   = 0;
    int   mx    = 0;
    int   early = 0;
    logic h;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) bus.fref = 8'(chg_fref);
      h = hold_gen(mode, i, p);
      bus.hold = h;
      if (h) run = 0;
      else if (run < 255) run++;
      if (h) ones++;
      if (run > mx) mx = run;
      tick();
      if (i < n - 1 && bus.valid) early++;
    end
    last_freq = ones / NBLK;
    last_max  = mx;
    check(tag, "early_valid", 32'(early), 0);
    check(tag, "valid", 32'(bus.valid), 1);
    check(tag, "freq_out", 32'(bus.freq_out), 32'(last_freq));
    check(tag, "max_stall", 32'(bus.max_stall), 32'(last_max));
    $display("[TB] window %s fref=%0d freq_out=%0d max_stall=%0d", tag, fr,
             bus.freq_out, bus.max_stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_busy;
    int bad_err;
    int nvalid;

    bus.enable = 1'b0;
    bus.hold   = 1'b0;
    bus.fref   = 8'd250;

    // Reset state
    repeat (3) tick();
    check("reset", "freq_out", 32'(bus.freq_out), 0);
    check("reset", "max_stall", 32'(bus.max_stall), 0);
    check("reset", "valid", 32'(bus.valid), 0);
    check("reset", "busy", 32'(bus.busy), 0);
    check("reset", "err", 32'(bus.err), 0);
    reset_n = 1'b1;
    tick();

    // Square 125/125 pattern, back-to-back windows
    start("t1", 250);
    run_window("t1a", 250, 0, 125, -1, 0);
    run_window("t1b", 250, 0, 125, -1, 0);
    check("t1", "freq_125", 32'(bus.freq_out), 125);

    // Stuck high / stuck low
    run_window("t2_high", 250, 1, 0, -1, 0);
    check("t2_high", "freq_250", 32'(bus.freq_out), 250);
    run_window("t2_low", 250, 2, 0, -1, 0);
    check("t2_low", "stall_sat", 32'(bus.max_stall), 255);

    // Random streams
    run_window("rand_a", 250, 3, 60, -1, 0);
    run_window("rand_b", 250, 3, 85, -1, 0);

    // Abort mid-window after a 125 result
    run_window("t4_pre", 250, 0, 125, -1, 0);
    nvalid = 0;
    for (int i = 0; i < 500; i++) begin
      bus.hold = hold_gen(3, i, 50);
      tick();
      if (bus.valid) nvalid++;
    end
    bus.enable = 1'b0;
    tick();
    check("t4", "busy", 32'(bus.busy), 0);
    check("t4", "valid", 32'(bus.valid), 0);
    check("t4", "freq_kept", 32'(bus.freq_out), 125);
    check("t4", "max_kept", 32'(bus.max_stall), 32'(last_max));
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.valid) nvalid++;
    end
    check("t4", "no_valid", 32'(nvalid), 0);

    // fref below 2: ARM/IDLE ping-pong with err set
    start("t3", 1);
    check("t3", "busy_idle", 32'(bus.busy), 0);
    bad_busy = 0;
    bad_err  = 0;
    nvalid   = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (bus.busy !== ((j % 2) == 0)) bad_busy++;
      if (bus.err !== 1'b1) bad_err++;
      if (bus.valid) nvalid++;
    end
    check("t3", "busy_toggle", 32'(bad_busy), 0);
    check("t3", "err_held", 32'(bad_err), 0);
    check("t3", "no_valid", 32'(nvalid), 0);
    bus.enable = 1'b0;
    repeat (2) tick();
    start("t3_recover", 250);

    // fref change mid-window takes effect on the next window
    run_window("t6a", 250, 0, 125, 500, 100);
    run_window("t6b", 100, 0, 50, -1, 0);
    check("t6b", "freq_50", 32'(bus.freq_out), 50);

    // Re-latched fref < 2 at window end: publish, then err and idle
    run_window("t7", 100, 3, 70, 200, 1);
    check("t7", "err", 32'(bus.err), 1);
    check("t7", "busy", 32'(bus.busy), 0);
    bus.enable = 1'b0;
    bus.fref   = 8'd250;
    tick();

    // Reset mid-window, then a clean restart
    start("t5", 250);
    for (int i = 0; i < 300; i++) begin
      bus.hold = hold_gen(3, i, 40);
      tick();
    end
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    tick();
    check("t5", "freq_out", 32'(bus.freq_out), 0);
    check("t5", "max_stall", 32'(bus.max_stall), 0);
    check("t5", "valid", 32'(bus.valid), 0);
    check("t5", "busy", 32'(bus.busy), 0);
    check("t5", "err", 32'(bus.err), 0);
    reset_n = 1'b1;
    tick();
    start("t5_restart", 250);
    run_window("t5_win", 250, 3, 30, -1, 0);
    tick();
    check("t5_win", "valid_pulse_end", 32'(bus.valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
